// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the jump opcode, the default address width and the FIFO entry layout.
package ifu_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int PC_MAX_W   = 32;

  localparam logic [5:0] OP_JUMP = 6'b010010;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [31:0]         inst;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bus: ROM port, redirect from execute, decoder-side valid/ready.
// master = fetch unit, slave = surrounding core (ROM, execute, decoder).
interface ifu_if #(
  parameter int ADDR_W = 6
);

  logic              fetch_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_inst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    input  fetch_en,
    output rom_addr,
    input  rom_inst,
    input  redirect_valid,
    input  redirect_addr,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc
  );

  modport slave (
    output fetch_en,
    input  rom_addr,
    output rom_inst,
    output redirect_valid,
    output redirect_addr,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc
  );

endinterface

// File: rtl/ifu_fifo2.sv
// Two-entry FIFO of {pc, inst}; flush wins over push/pop.
// Ports: clk, rst, push, pop, flush, din, head (zero when empty), full, empty.
module ifu_fifo2
  import ifu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  ifu_entry_t din,
  output ifu_entry_t head,
  output logic       full,
  output logic       empty
);

  ifu_entry_t mem [2];
  logic       wp;
  logic       rp;
  logic [1:0] cnt;

  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign head  = empty ? '0 : mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC register feeding a 2-entry {pc, inst} buffer.
// Ports: clk, rst, bus (ifu_if.master). Option: IFU_JUMP_PREDECODE_EN.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic   clk,
  input  logic   rst,
  ifu_if.master  bus
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  ifu_entry_t        din;
  ifu_entry_t        head;

  assign pop  = bus.out_valid & bus.out_ready;
  assign push = bus.fetch_en & ~bus.redirect_valid
              & (~full | pop);

  assign din.pc   = PC_MAX_W'(pc);
  assign din.inst = bus.rom_inst;

`ifdef IFU_JUMP_PREDECODE_EN
  assign next_pc = (bus.rom_inst[31:26] == OP_JUMP)
                 ? bus.rom_inst[ADDR_W-1:0]
                 : pc + ADDR_W'(1);
`else
  assign next_pc = pc + ADDR_W'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     pc <= RESET_PC;
    else if (bus.redirect_valid) pc <= bus.redirect_addr;
    else if (push)               pc <= next_pc;
  end

  ifu_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.rom_addr  = pc;
  assign bus.out_valid = ~empty;
  assign bus.out_inst  = head.inst;
  assign bus.out_pc    = head.pc[ADDR_W-1:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit.
// Behavioural ROM answers rom_addr combinationally.
module tb_inst_fetch_unit;

  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  logic [31:0] rom [64];

  ifu_if #(.ADDR_W(AW)) bus ();

  inst_fetch_unit #(.ADDR_W(AW), .RESET_PC(6'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rom_inst = rom[bus.rom_addr];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.fetch_en       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b1;
    do_reset();
    rst = 1'b1;
    #1;
    nvec++;
    if (bus.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_valid got %0b want 0", bus.out_valid);
    end
    nvec++;
    if (bus.out_pc !== 6'd0 || bus.out_inst !== 32'd0) begin
      nerr++;
      $display("FAIL reset_out got pc=%0h inst=%0h want 0/0",
               bus.out_pc, bus.out_inst);
    end
    nvec++;
    if (bus.rom_addr !== 6'd0) begin
      nerr++;
      $display("FAIL reset_addr got %0h want 0", bus.rom_addr);
    end
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== AW'(i)
          || bus.out_inst !== rom[i]) begin
        nerr++;
        $display("FAIL seq%0d got v=%0b pc=%0h inst=%0h want 1/%0h/%0h",
                 i, bus.out_valid, bus.out_pc, bus.out_inst, i, rom[i]);
      end
      step();
    end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    do_reset();
    repeat (5) step();
    nvec++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 6'd0
        || bus.rom_addr !== 6'd2) begin
      nerr++;
      $display("FAIL stall_hold got v=%0b pc=%0h addr=%0h want 1/0/2",
               bus.out_valid, bus.out_pc, bus.rom_addr);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== AW'(i)
          || bus.out_inst !== rom[i]) begin
        nerr++;
        $display("FAIL stall_drain%0d got v=%0b pc=%0h want 1/%0h",
                 i, bus.out_valid, bus.out_pc, i);
      end
      step();
    end
  endtask

  task automatic test_redirect();
    bus.out_ready = 1'b0;
    do_reset();
    repeat (2) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 6'h0B;
    bus.out_ready      = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    nvec++;
    if (bus.out_valid !== 1'b0 || bus.rom_addr !== 6'h0B
        || bus.out_pc !== 6'd0) begin
      nerr++;
      $display("FAIL redir_flush got v=%0b addr=%0h pc=%0h want 0/b/0",
               bus.out_valid, bus.rom_addr, bus.out_pc);
    end
    step();
    nvec++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 6'h0B
        || bus.out_inst !== rom[11]) begin
      nerr++;
      $display("FAIL redir_target got v=%0b pc=%0h inst=%0h want 1/b/%0h",
               bus.out_valid, bus.out_pc, bus.out_inst, rom[11]);
    end
  endtask

  task automatic test_wrap();
    bus.out_ready = 1'b1;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 6'h3F;
    step();
    bus.redirect_valid = 1'b0;
    step();
    nvec++;
    if (bus.out_pc !== 6'h3F || bus.out_inst !== rom[63]) begin
      nerr++;
      $display("FAIL wrap_3f got pc=%0h want 3f", bus.out_pc);
    end
    step();
    nvec++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 6'h00) begin
      nerr++;
      $display("FAIL wrap_00 got v=%0b pc=%0h want 1/0",
               bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_jump();
    logic [AW-1:0] exp2;
`ifdef IFU_JUMP_PREDECODE_EN
    exp2 = 6'h0B;
`else
    exp2 = 6'h08;
`endif
    bus.out_ready = 1'b1;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 6'd7;
    step();
    bus.redirect_valid = 1'b0;
    step();
    nvec++;
    if (bus.out_pc !== 6'd7 || bus.out_inst !== 32'h4800000B) begin
      nerr++;
      $display("FAIL jump_self got pc=%0h inst=%0h want 7/4800000b",
               bus.out_pc, bus.out_inst);
    end
    step();
    nvec++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== exp2) begin
      nerr++;
      $display("FAIL jump_next got v=%0b pc=%0h want 1/%0h",
               bus.out_valid, bus.out_pc, exp2);
    end
  endtask

  task automatic test_fetch_en();
    bus.out_ready = 1'b0;
    do_reset();
    repeat (2) step();
    bus.fetch_en  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    nvec++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 6'd1
        || bus.rom_addr !== 6'd2) begin
      nerr++;
      $display("FAIL fen_drain got v=%0b pc=%0h addr=%0h want 1/1/2",
               bus.out_valid, bus.out_pc, bus.rom_addr);
    end
    step();
    nvec++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 6'd0
        || bus.out_inst !== 32'd0 || bus.rom_addr !== 6'd2) begin
      nerr++;
      $display("FAIL fen_empty got v=%0b pc=%0h inst=%0h addr=%0h want 0/0/0/2",
               bus.out_valid, bus.out_pc, bus.out_inst, bus.rom_addr);
    end
    bus.fetch_en = 1'b1;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    do_reset();
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 6'd0
        || bus.out_inst !== 32'd0 || bus.rom_addr !== 6'd0) begin
      nerr++;
      $display("FAIL arst_now got v=%0b pc=%0h inst=%0h addr=%0h want 0/0/0/0",
               bus.out_valid, bus.out_pc, bus.out_inst, bus.rom_addr);
    end
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    nvec++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 6'd0
        || bus.out_inst !== rom[0]) begin
      nerr++;
      $display("FAIL arst_restart got v=%0b pc=%0h want 1/0",
               bus.out_valid, bus.out_pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | i;
    rom[7] = 32'h4800_000B;
    bus.fetch_en       = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    #2;
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_jump();
    test_fetch_en();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 6, sets the instruction word-address width, i.e. the ROM depth of 2^ADDR_W words.
REQ-002 Parameter RESET_PC, default 0, sets the PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fetch_en  input  1  when 0, no new fetch is issued; buffered entries still drain.
REQ-006 rom_addr  output  ADDR_W  word address driven to the instruction ROM; equals the current PC.
REQ-007 rom_inst  input  32  ROM data; combinational response to rom_addr within the same cycle.
REQ-008 redirect_valid  input  1  taken branch/jump from execute; flushes and reloads the PC.
REQ-009 redirect_addr  input  ADDR_W  target word address for a redirect.
REQ-010 out_valid  output  1  the head entry is valid.
REQ-011 out_ready  input  1  the decoder accepts the head entry this cycle.
REQ-012 out_inst  output  32  head instruction.
REQ-013 out_pc  output  ADDR_W  word address of the head instruction.

Function
REQ-014 The unit shall contain a PC register and a 2-entry FIFO of {pc, inst} pairs.
REQ-015 Push condition: fetch_en=1, redirect_valid=0, and (FIFO not full, or a pop occurs in the same cycle); {PC, rom_inst} is written at the clock edge.
REQ-016 Each push shall advance the PC to the next PC; without a redirect the next PC is PC+1 modulo 2^ADDR_W, so 63 wraps to 0.
REQ-017 Pop condition: out_valid=1 and out_ready=1; the head advances at the edge.
REQ-018 Latency: an instruction fetched in cycle N shall appear at out_* in cycle N+1 when the FIFO was empty.
REQ-019 Simultaneous push and pop shall keep the occupancy unchanged and preserve order.
REQ-020 When the FIFO is full and no pop occurs, the PC shall hold and no push shall occur.
REQ-021 redirect_valid=1 shall empty the FIFO and load PC<=redirect_addr at the edge, with no push that cycle; any simultaneous pop is discarded.
REQ-022 out_valid shall be 0 when empty, and out_inst/out_pc shall then be 0.
REQ-023 fetch_en=0 shall hold the PC while pops continue.
REQ-024 Outputs shall be registered or derived from FIFO state only, with no combinational path from rom_inst to out_*.

Reset
REQ-025 Asserting rst at any time, including mid-stream, shall force PC=RESET_PC, FIFO empty, out_valid=0, out_inst=0, out_pc=0.
REQ-026 Fetching shall resume in the first cycle after rst deasserts, with rom_addr=RESET_PC.

Configuration
REQ-027 Macro IFU_JUMP_PREDECODE_EN: when defined, a pushed instruction with rom_inst[31:26]=6'b010010 (jump) shall set next PC=rom_inst[ADDR_W-1:0] instead of PC+1; the jump itself is still pushed.
REQ-028 Without IFU_JUMP_PREDECODE_EN, the next PC is always sequential, and jumps are resolved only through redirect_valid.

Structure
REQ-029 Package ifu_pkg shall hold the OP_JUMP opcode constant, the default ADDR_W, and the FIFO-entry struct {pc, inst}.
REQ-030 The FIFO shall be a sub-module ifu_fifo2 (depth 2, push/pop/flush, full/empty).

Verification
REQ-031 Reset, fetch_en=1, out_ready=1 with ROM words 0..3 preloaded -> out_pc sequence 0,1,2,3 starting the cycle after reset, out_inst matching ROM.
REQ-032 out_ready=0 for 5 cycles -> out_valid=1, PC stalls at 2 with entries 0,1 held; release -> 0,1,2 delivered in order with no loss or duplication.
REQ-033 redirect_valid=1, redirect_addr=0x0B while the FIFO is full -> next cycle out_valid=0, rom_addr=0x0B; the cycle after, out_pc=0x0B.
REQ-034 PC=0x3F, continuous fetch -> out_pc 0x3F then 0x00.
REQ-035 With IFU_JUMP_PREDECODE_EN, ROM[7]=0x4800000B -> out_pc sequence 7, 0x0B; without the macro -> 7, 8.
REQ-036 rst pulsed mid-stream with 2 entries buffered -> out_valid=0 immediately (asynchronous), then restart at RESET_PC.
